// File: rtl/pkg_rv32_types.sv
// Shared RV32 types for the M-extension sequencer: operation and state encodings
// plus a small two's-complement helper.
package pkg_rv32_types;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient bit per step.
// quo_o/rem_o show the values after the step in flight so the last step can be consumed directly.
module rv32_div_iter
  import pkg_rv32_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN:0]   part_s;
  logic [XLEN-1:0] sub_s;
  logic            ge_s;

  // Trial subtraction; remainder stays below the divisor so the low word of the difference is exact.
  always_comb begin
    part_s = {rem_q, quo_q[XLEN-1]};
    sub_s  = part_s[XLEN-1:0] - dvs_q;
    ge_s   = (part_s >= {1'b0, dvs_q});
    quo_o  = {quo_q[XLEN-2:0], ge_s};
    if (ge_s) begin
      rem_o = sub_s;
    end else begin
      rem_o = part_s[XLEN-1:0];
    end
  end

  // Operand load and per-step shift of the quotient/remainder pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= {XLEN{1'b0}};
      rem_q <= {XLEN{1'b0}};
      dvs_q <= {XLEN{1'b0}};
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= {XLEN{1'b0}};
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
    end else begin
      quo_q <= quo_q;
      rem_q <= rem_q;
    end
  end

endmodule

// File: rtl/rv32_mdu_sequencer.sv
// Multi-cycle M-extension sequencer: stalls the single-cycle core while a multiply (1 cycle)
// or restoring divide (32 cycles) runs, then presents a registered result for one writeback cycle.
module rv32_mdu_sequencer
  import pkg_rv32_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            done,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  mdu_state_e      state_q;
  mdu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [4:0]      cnt_q;
  logic            done_q, busy_q;

  logic            in_signed_s, in_rem_s, div_zero_s, ovf_s, special_s, div_load_s, div_step_s;
  logic [XLEN-1:0] spec_res_d, dvd_mag_s, dvs_mag_s, mul_res_d, div_res_d, quo_s, rem_s;
  logic [2*XLEN-1:0] a_w_s, b_w_s, prod_s;
  logic            a_sx_s, b_sx_s, neg_q_s, neg_r_s;

  // Special-case detection and divider entry values from the live operands.
  always_comb begin
    in_signed_s = ~m_op[0];
    in_rem_s    = m_op[1];
    div_zero_s  = (rs2_data == {XLEN{1'b0}});
    ovf_s       = in_signed_s & (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);
    special_s   = m_op[2] & (div_zero_s | ovf_s);
    if (div_zero_s) begin
      spec_res_d = in_rem_s ? rs1_data : {XLEN{1'b1}};
    end else begin
      spec_res_d = in_rem_s ? {XLEN{1'b0}} : 32'h8000_0000;
    end
    div_load_s = (state_q == ST_IDLE) & m_valid & m_op[2] & ~special_s;
    div_step_s = (state_q == ST_DIV);
    dvd_mag_s  = neg_if(rs1_data, in_signed_s & rs1_data[XLEN-1]);
    dvs_mag_s  = neg_if(rs2_data, in_signed_s & rs2_data[XLEN-1]);
  end

  // Multiplier (only MULHU leaves A unsigned, only MULH/MUL sign B) and divide sign fixup.
  always_comb begin
    a_sx_s = ~(op_q[1] & op_q[0]) & a_q[XLEN-1];
    b_sx_s = ~op_q[1] & b_q[XLEN-1];
    a_w_s  = {{XLEN{a_sx_s}}, a_q};
    b_w_s  = {{XLEN{b_sx_s}}, b_q};
    prod_s = a_w_s * b_w_s;
    if (op_q == MDU_MUL) begin
      mul_res_d = prod_s[XLEN-1:0];
    end else begin
      mul_res_d = prod_s[2*XLEN-1:XLEN];
    end
    neg_q_s = ~op_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    neg_r_s = ~op_q[0] & a_q[XLEN-1];
    if (op_q[1]) begin
      div_res_d = neg_if(rem_s, neg_r_s);
    end else begin
      div_res_d = neg_if(quo_s, neg_q_s);
    end
  end

  rv32_div_iter u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load_s),
    .step_i     (div_step_s),
    .dividend_i (dvd_mag_s),
    .divisor_i  (dvs_mag_s),
    .quo_o      (quo_s),
    .rem_o      (rem_s)
  );

  // Sequencer FSM with registered result, done and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MDU_MUL;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      cnt_q    <= 5'd0;
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (m_valid) begin
            a_q    <= rs1_data;
            b_q    <= rs2_data;
            op_q   <= mdu_op_e'(m_op);
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
            if (!m_op[2]) begin
              state_q <= ST_MUL;
            end else if (special_s) begin
              result_q <= spec_res_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q <= ST_DIV;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_MUL: begin
          result_q <= mul_res_d;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DIV: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITERS - 1)) begin
            result_q <= div_res_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall  = m_valid & ~done_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv32_mdu_sequencer.sv
// Self-checking bench: directed cases plus randomized ops against an arithmetic reference model.
module tb_rv32_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, m_valid, stall, done, busy;
  logic [2:0]  m_op;
  logic [31:0] rs1_data, rs2_data, result;

  int n_checks = 0;
  int n_errors = 0;

  rv32_mdu_sequencer dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_op(m_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .done(done), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op (caller is just after a rising edge); optionally drop m_valid and scramble inputs after capture.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit drop);
    int done_cyc = -1;
    int stalls = 0;
    logic [31:0] got = 32'h0;
    bit fin = 1'b0;
    m_valid = 1'b1; m_op = op; rs1_data = a; rs2_data = b;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        fin = 1'b1; done_cyc = k; got = result;
      end
      @(posedge clk); #1;
      if (k == 0 && drop) begin
        m_valid = 1'b0; m_op = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
      end
    end
    m_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(done_cyc), 32'(ref_latency(op, a, b)));
    check_eq({tag, "_res"}, got, ref_result(op, a, b));
    if (!drop) check_eq({tag, "_stall"}, 32'(stalls), 32'(ref_latency(op, a, b)));
  endtask

  initial begin
    int dcyc [2];
    logic [31:0] dres [2];
    int nd;
    bit seen;
    logic [2:0] op;
    logic [31:0] a, b;

    rst = 1'b1; m_valid = 1'b0; m_op = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 1'b0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 1'b0);
    run_op("div0", 3'd4, 32'd5, 32'd0, 1'b0);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 1'b0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_pre", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);

    // Reset during the divide: no done pulse, outputs back to reset values.
    seen = 1'b0;
    m_valid = 1'b1; m_op = 3'd4; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    if (done) seen = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_done_seen", {31'd0, seen | done}, 32'd0);
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    check_eq("mrst_result", result, 32'd0);
    @(posedge clk); #1;
    run_op("divu_after_rst", 3'd5, 32'd100, 32'd7, 1'b0);

    // Back-to-back MUL then DIVU, operands scrambled mid-divide.
    nd = 0; dcyc[0] = -1; dcyc[1] = -1; dres[0] = 32'h0; dres[1] = 32'h0;
    for (int g = 0; g < 45; g++) begin
      if (g <= 2) begin
        m_valid = 1'b1; m_op = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD;
      end else if (g <= 36) begin
        m_valid = 1'b1; m_op = 3'd5;
        if (g < 10) begin
          rs1_data = 32'd100; rs2_data = 32'd7;
        end else begin
          rs1_data = $urandom; rs2_data = $urandom;
        end
      end else begin
        m_valid = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        if (nd < 2) begin
          dcyc[nd] = g; dres[nd] = result;
        end
        nd++;
      end
      @(posedge clk); #1;
    end
    check_eq("b2b_count", 32'(nd), 32'd2);
    check_eq("b2b_cyc0", 32'(dcyc[0]), 32'd2);
    check_eq("b2b_cyc1", 32'(dcyc[1]), 32'd36);
    check_eq("b2b_res0", dres[0], 32'hFFFF_FFEB);
    check_eq("b2b_res1", dres[1], 32'd14);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
